// File: rtl/bitty_alu_sequencer_pkg.sv
// Shared types and instruction-field constants for the bitty ALU sequencer.
// Optional retired-instruction counter is enabled with BITTY_SEQ_PERF_EN.
package bitty_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_A   = 3'd1,
        S_EXEC     = 3'd2,
        S_WB       = 3'd3,
        S_DONE_NOP = 3'd4
    } state_e;

    localparam int INSTR_W       = 16;
    localparam int NUM_REGS_DFLT = 8;
    localparam int REG_IDX_W     = $clog2(NUM_REGS_DFLT);

    localparam int RX_LO    = 13;
    localparam int RY_LO    = 10;
    localparam int SEL_LO   = 6;
    localparam int MODE_BIT = 5;
    localparam int FMT_LO   = 0;

    localparam logic [1:0] FMT_RTYPE = 2'b00;

    // Read-mux code that selects the C (result) register instead of a GPR.
    localparam int MUX_SEL_C = NUM_REGS_DFLT;

endpackage

// File: rtl/bitty_alu_sequencer_if.sv
// Instruction handshake and datapath-control bundle of the bitty ALU sequencer.
// retired_count exists only when BITTY_SEQ_PERF_EN is defined.
interface bitty_alu_sequencer_if #(
    parameter int NUM_REGS  = 8,
    parameter int MUX_SEL_W = 4
`ifdef BITTY_SEQ_PERF_EN
    ,
    parameter int COUNT_W   = 16
`endif
);
    logic                 run;
    logic [15:0]          instruction;
    logic                 alu_carry;
    logic                 alu_compare;
    logic [MUX_SEL_W-1:0] mux_sel;
    logic                 en_s;
    logic                 en_c;
    logic [NUM_REGS-1:0]  en_i;
    logic [3:0]           alu_sel;
    logic                 alu_mode;
    logic                 flag_carry;
    logic                 flag_eq;
    logic                 done;
    logic                 illegal;
    logic                 busy;
`ifdef BITTY_SEQ_PERF_EN
    logic [COUNT_W-1:0]   retired_count;
`endif

    modport master (
        input  run, instruction, alu_carry, alu_compare,
        output mux_sel, en_s, en_c, en_i, alu_sel, alu_mode,
        output flag_carry, flag_eq, done, illegal, busy
`ifdef BITTY_SEQ_PERF_EN
        , output retired_count
`endif
    );

    modport slave (
        output run, instruction, alu_carry, alu_compare,
        input  mux_sel, en_s, en_c, en_i, alu_sel, alu_mode,
        input  flag_carry, flag_eq, done, illegal, busy
`ifdef BITTY_SEQ_PERF_EN
        , input retired_count
`endif
    );

endinterface

// File: rtl/bitty_alu_sequencer_decode.sv
// Combinational field split of a bitty instruction word.
// Unaffected by BITTY_SEQ_PERF_EN.
module bitty_instr_decode
    import bitty_seq_pkg::*;
(
    input  logic [INSTR_W-1:0]   instr_i,
    output logic [REG_IDX_W-1:0] rx_o,
    output logic [REG_IDX_W-1:0] ry_o,
    output logic [3:0]           alu_sel_o,
    output logic                 alu_mode_o,
    output logic                 is_rtype_o
);

    // Reserved bits [4:2] carry no meaning; fold them away explicitly.
    logic unused_rsvd_s;

    assign rx_o          = instr_i[RX_LO +: REG_IDX_W];
    assign ry_o          = instr_i[RY_LO +: REG_IDX_W];
    assign alu_sel_o     = instr_i[SEL_LO +: 4];
    assign alu_mode_o    = instr_i[MODE_BIT];
    assign is_rtype_o    = (instr_i[FMT_LO +: 2] == FMT_RTYPE);
    assign unused_rsvd_s = ^instr_i[4:2];

endmodule

// File: rtl/bitty_alu_sequencer.sv
// Multi-cycle sequencer: one register-register ALU op per accepted instruction.
// Define BITTY_SEQ_PERF_EN to add the wrapping retired_count output.
module bitty_alu_sequencer
    import bitty_seq_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int MUX_SEL_W = 4
`ifdef BITTY_SEQ_PERF_EN
    ,
    parameter int COUNT_W   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bitty_alu_sequencer_if.master bus
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [MUX_SEL_W-1:0] mux_sel_q, mux_sel_d;
    logic                 en_s_q, en_s_d, en_c_q, en_c_d;
    logic [NUM_REGS-1:0]  en_i_q, en_i_d;
    logic [3:0]           alu_sel_q, alu_sel_d;
    logic                 alu_mode_q, alu_mode_d;
    logic                 flag_carry_q, flag_carry_d, flag_eq_q, flag_eq_d;
    logic                 done_q, done_d, illegal_q, illegal_d, busy_q, busy_d;
    logic                 accept_s;

    logic [REG_IDX_W-1:0] rx_s, ry_s;
    logic [3:0]           alu_sel_s;
    logic                 alu_mode_s, is_rtype_s;

    // Decode the instruction that will be held next cycle, so every output can be registered.
    bitty_instr_decode u_decode (
        .instr_i    (instr_d),
        .rx_o       (rx_s),
        .ry_o       (ry_s),
        .alu_sel_o  (alu_sel_s),
        .alu_mode_o (alu_mode_s),
        .is_rtype_o (is_rtype_s)
    );

    assign accept_s = bus.run && ((state_q == S_IDLE) || (state_q == S_WB) || (state_q == S_DONE_NOP));

    // Instruction latch: only updated on an accepted run.
    always_comb begin
        if (accept_s) begin
            instr_d = bus.instruction;
        end else begin
            instr_d = instr_q;
        end
    end

    // Next state, flag capture and next-cycle control outputs.
    always_comb begin
        state_d      = state_q;
        flag_carry_d = flag_carry_q;
        flag_eq_d    = flag_eq_q;
        case (state_q)
            S_IDLE, S_WB, S_DONE_NOP: begin
                if (accept_s) begin
                    state_d = is_rtype_s ? S_LOAD_A : S_DONE_NOP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_A: state_d = S_EXEC;
            S_EXEC: begin
                state_d      = S_WB;
                flag_carry_d = bus.alu_carry;
                flag_eq_d    = bus.alu_compare;
            end
            default: state_d = S_IDLE;
        endcase

        mux_sel_d = {MUX_SEL_W{1'b0}};
        en_s_d    = 1'b0;
        en_c_d    = 1'b0;
        en_i_d    = {NUM_REGS{1'b0}};
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_d)
            S_LOAD_A: begin
                mux_sel_d = {{(MUX_SEL_W-REG_IDX_W){1'b0}}, rx_s};
                en_s_d    = 1'b1;
            end
            S_EXEC: begin
                mux_sel_d = {{(MUX_SEL_W-REG_IDX_W){1'b0}}, ry_s};
                en_c_d    = 1'b1;
            end
            S_WB: begin
                mux_sel_d = MUX_SEL_W'(MUX_SEL_C);
                en_i_d    = {{(NUM_REGS-1){1'b0}}, 1'b1} << rx_s;
                done_d    = 1'b1;
            end
            S_DONE_NOP: begin
                done_d    = 1'b1;
                illegal_d = 1'b1;
            end
            default: begin
                mux_sel_d = {MUX_SEL_W{1'b0}};
            end
        endcase

        if (state_d != S_IDLE) begin
            alu_sel_d  = alu_sel_s;
            alu_mode_d = alu_mode_s;
            busy_d     = 1'b1;
        end else begin
            alu_sel_d  = 4'd0;
            alu_mode_d = 1'b0;
            busy_d     = 1'b0;
        end
    end

    // FSM state, instruction latch, flags and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            instr_q      <= {INSTR_W{1'b0}};
            mux_sel_q    <= {MUX_SEL_W{1'b0}};
            en_s_q       <= 1'b0;
            en_c_q       <= 1'b0;
            en_i_q       <= {NUM_REGS{1'b0}};
            alu_sel_q    <= 4'd0;
            alu_mode_q   <= 1'b0;
            flag_carry_q <= 1'b0;
            flag_eq_q    <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            mux_sel_q    <= mux_sel_d;
            en_s_q       <= en_s_d;
            en_c_q       <= en_c_d;
            en_i_q       <= en_i_d;
            alu_sel_q    <= alu_sel_d;
            alu_mode_q   <= alu_mode_d;
            flag_carry_q <= flag_carry_d;
            flag_eq_q    <= flag_eq_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mux_sel    = mux_sel_q;
    assign bus.en_s       = en_s_q;
    assign bus.en_c       = en_c_q;
    assign bus.en_i       = en_i_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.alu_mode   = alu_mode_q;
    assign bus.flag_carry = flag_carry_q;
    assign bus.flag_eq    = flag_eq_q;
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;
    assign bus.busy       = busy_q;

`ifdef BITTY_SEQ_PERF_EN
    logic [COUNT_W-1:0] count_q, count_d;

    // Count advances in the same cycle the done pulse is presented; wraps naturally.
    always_comb begin
        if (done_d) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= {COUNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.retired_count = count_q;
`endif

endmodule

// File: tb/tb_bitty_alu_sequencer.sv
// Scoreboard bench for bitty_alu_sequencer; counter wrap checked when BITTY_SEQ_PERF_EN is defined.
module tb_bitty_alu_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   tests = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitty_alu_sequencer_if #(.NUM_REGS(8), .MUX_SEL_W(4)
`ifdef BITTY_SEQ_PERF_EN
        , .COUNT_W(4)
`endif
    ) bus ();

    bitty_alu_sequencer #(.NUM_REGS(8), .MUX_SEL_W(4)
`ifdef BITTY_SEQ_PERF_EN
        , .COUNT_W(4)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Small datapath model: fixed register file, S register, adder-style carry and equality.
    logic [15:0] regs [8];
    logic [15:0] s_mdl = 16'd0;
    logic [15:0] b_mdl;
    logic [16:0] sum_mdl;
    always @(posedge clk) if (bus.en_s) s_mdl <= regs[bus.mux_sel[2:0]];
    assign b_mdl           = regs[bus.mux_sel[2:0]];
    assign sum_mdl         = {1'b0, s_mdl} + {1'b0, b_mdl};
    assign bus.alu_carry   = sum_mdl[16];
    assign bus.alu_compare = (s_mdl == b_mdl);

    typedef struct {
        int         cyc;
        logic [3:0] mux;
        logic       es;
        logic       ec;
        logic [7:0] ei;
        logic [3:0] sel;
        logic       mode;
        logic       dn;
        logic       ill;
        logic       chkf;
        logic       fc;
        logic       fe;
    } rec_t;
    rec_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] mux, input logic es, input logic ec,
                        input logic [7:0] ei, input logic [3:0] sel, input logic mode,
                        input logic dn, input logic ill, input logic chkf, input logic fc, input logic fe);
        rec_t r;
        r.cyc = c; r.mux = mux; r.es = es; r.ec = ec; r.ei = ei; r.sel = sel; r.mode = mode;
        r.dn = dn; r.ill = ill; r.chkf = chkf; r.fc = fc; r.fe = fe;
        q.push_back(r);
    endtask

    // Monitor: every active cycle must match the next expected record.
    always @(negedge clk) begin
        if (reset_n && (bus.busy || bus.en_s || bus.en_c || (bus.en_i != 8'd0) || bus.done || bus.illegal)) begin
            chk("excl_enables", 32'($countones({bus.en_s, bus.en_c, |bus.en_i}) <= 1), 32'd1);
            if (q.size() == 0) begin
                chk("unexpected_activity", 32'({bus.busy, bus.done, bus.illegal, bus.en_s, bus.en_c, bus.en_i}), 32'd0);
            end else begin
                rec_t r;
                r = q.pop_front();
                chk("cycle",    32'(cyc),          32'(r.cyc));
                chk("mux_sel",  32'(bus.mux_sel),  32'(r.mux));
                chk("en_s",     32'(bus.en_s),     32'(r.es));
                chk("en_c",     32'(bus.en_c),     32'(r.ec));
                chk("en_i",     32'(bus.en_i),     32'(r.ei));
                chk("alu_sel",  32'(bus.alu_sel),  32'(r.sel));
                chk("alu_mode", 32'(bus.alu_mode), 32'(r.mode));
                chk("done",     32'(bus.done),     32'(r.dn));
                chk("illegal",  32'(bus.illegal),  32'(r.ill));
                chk("busy",     32'(bus.busy),     32'd1);
                if (r.chkf) begin
                    chk("flag_carry", 32'(bus.flag_carry), 32'(r.fc));
                    chk("flag_eq",    32'(bus.flag_eq),    32'(r.fe));
                end
            end
        end
    end

    task automatic chk_idle(input string pfx);
        chk({pfx, "_mux_sel"},  32'(bus.mux_sel),  32'd0);
        chk({pfx, "_enables"},  32'({bus.en_s, bus.en_c, bus.en_i}), 32'd0);
        chk({pfx, "_alu"},      32'({bus.alu_sel, bus.alu_mode}), 32'd0);
        chk({pfx, "_pulses"},   32'({bus.done, bus.illegal, bus.busy}), 32'd0);
    endtask

    // R-type issue: returns in the write-back cycle, ready for back-to-back issue.
    task automatic issue_r(input logic [15:0] ins, input logic [2:0] rx, input logic [2:0] ry,
                           input logic [3:0] sel, input logic mode, input logic fc, input logic fe,
                           input logic noise);
        int a;
        bus.run = 1'b1;
        bus.instruction = ins;
        @(posedge clk); #1;
        a = cyc;
        push(a,     {1'b0, rx}, 1'b1, 1'b0, 8'd0, sel, mode, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(a + 1, {1'b0, ry}, 1'b0, 1'b1, 8'd0, sel, mode, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(a + 2, 4'd8, 1'b0, 1'b0, 8'd1 << rx, sel, mode, 1'b1, 1'b0, 1'b1, fc, fe);
        for (int k = 0; k < 2; k++) begin
            if (noise) begin
                bus.run = (k == 0) ? 1'b0 : 1'b1;
                bus.instruction = (k == 0) ? 16'hFFFF : 16'h5A5B;
            end
            @(posedge clk); #1;
        end
    endtask

    // Illegal issue: returns in the done/illegal cycle.
    task automatic issue_ill(input logic [15:0] ins, input logic [3:0] sel, input logic mode);
        int a;
        bus.run = 1'b1;
        bus.instruction = ins;
        @(posedge clk); #1;
        a = cyc;
        push(a, 4'd0, 1'b0, 1'b0, 8'd0, sel, mode, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go_idle();
        bus.run = 1'b0;
        bus.instruction = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        regs[0] = 16'h0001; regs[1] = 16'h8000; regs[2] = 16'h0002; regs[3] = 16'h0003;
        regs[4] = 16'h0004; regs[5] = 16'h0005; regs[6] = 16'h0006; regs[7] = 16'h1234;
        reset_n = 1'b0;
        bus.run = 1'b0;
        bus.instruction = 16'h0000;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_flags", 32'({bus.flag_carry, bus.flag_eq}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ADD r1,r1: 0x8000+0x8000 carries and compares equal
        issue_r(16'h2640, 3'd1, 3'd1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        go_idle();
        chk("add_flags_hold", 32'({bus.flag_carry, bus.flag_eq}), 32'd3);
        chk_idle("idle1");

        // XOR mode 1, rx=7 ry=0
        issue_r(16'hE1A0, 3'd7, 3'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        go_idle();

        // Back-to-back: R, illegal (fmt 01), R with run held high
        issue_r(16'hE1A0, 3'd7, 3'd0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        issue_ill(16'h4AE1, 4'd11, 1'b1);
        issue_r(16'h2640, 3'd1, 3'd1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        go_idle();

        // Reset asserted during S_EXEC abandons the instruction
        bus.run = 1'b1;
        bus.instruction = 16'h2640;
        @(posedge clk); #1;
        push(cyc, 4'd1, 1'b1, 1'b0, 8'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.run = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_idle("midrst");
        chk("midrst_flags", 32'({bus.flag_carry, bus.flag_eq}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("postrst_no_en_i", 32'(bus.en_i), 32'd0);
        end

        // Illegal format right after reset: done+illegal only, flags untouched
        issue_ill(16'h0003, 4'd0, 1'b0);
        go_idle();
        chk("ill_flags", 32'({bus.flag_carry, bus.flag_eq}), 32'd0);

        // run/instruction toggled during LOAD_A/EXEC are ignored
        issue_r(16'h2640, 3'd1, 3'd1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        go_idle();
        chk_idle("idle2");

`ifdef BITTY_SEQ_PERF_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("cnt_reset", 32'(bus.retired_count), 32'd0);
        for (int k = 0; k < 17; k++) begin
            issue_ill(16'h0001, 4'd0, 1'b0);
            if (k == 15) chk("cnt_wrap0", 32'(bus.retired_count), 32'd0);
        end
        go_idle();
        chk("cnt_after17", 32'(bus.retired_count), 32'd1);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/bitty_alu_sequencer.md
Name: bitty_alu_sequencer

Overview:
- Multi-cycle controller that sequences one register-register ALU operation per instruction for the bitty 16-bit datapath.
- Accepts an instruction on a run/done handshake and latches it.
- Drives the register-file read mux, the operand (S) and result (C) register enables, the ALU select/mode lines, and per-register write enables.
- Captures ALU carry and compare into flag registers; sits between instruction fetch and the register/ALU datapath.

Parameters:
- NUM_REGS, 8, number of general registers; register index width is clog2(NUM_REGS).
- MUX_SEL_W, 4, width of read-mux select; value NUM_REGS selects the C (result) register.
- COUNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  instruction valid; sampled in S_IDLE, and in S_WB/S_DONE_NOP for back-to-back issue
- instruction  in  16  instruction word; sampled only when it is accepted
- alu_carry  in  1  ALU carry_out
- alu_compare  in  1  ALU compare (in_a == in_b)
- mux_sel  out  MUX_SEL_W  read-mux select
- en_s  out  1  load S register (ALU in_a) from mux
- en_c  out  1  load C register from ALU output
- en_i  out  NUM_REGS  one-hot register write enable
- alu_sel  out  4  ALU select
- alu_mode  out  1  ALU mode (0 arithmetic, 1 logic)
- flag_carry  out  1  registered carry of last executed op
- flag_eq  out  1  registered compare of last executed op
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse with done when the format is not R-type
- busy  out  1  high in every state except S_IDLE

Behaviour:
- Instruction fields:
  - [15:13] rx, destination and in_a source.
  - [12:10] ry, in_b source.
  - [9:6] alu_sel.
  - [5] alu_mode.
  - [4:2] reserved, ignored.
  - [1:0] fmt: 00 = R-type; 01/10/11 = illegal.
- Reset, asynchronous on reset_n low:
  - State goes to S_IDLE; the latched instruction is cleared to 0.
  - All enables, done, illegal and busy are 0; flags are 0; mux_sel is 0.
  - Reset mid-operation abandons the instruction; no en_i is issued.
- S_IDLE:
  - Outputs are idle.
  - If run=1, latch instruction; go to S_LOAD_A if fmt=00, else S_DONE_NOP.
- S_LOAD_A: mux_sel=rx, en_s=1. Go to S_EXEC.
- S_EXEC:
  - mux_sel=ry; alu_sel/alu_mode driven from the latch; en_c=1.
  - At the clock edge, flag_carry<=alu_carry and flag_eq<=alu_compare.
  - Go to S_WB.
- S_WB:
  - mux_sel=NUM_REGS (C register); en_i[rx]=1, all other bits 0; done=1.
  - If run=1, latch the new instruction and go to S_LOAD_A or S_DONE_NOP; else go to S_IDLE.
- S_DONE_NOP:
  - done=1, illegal=1; no register or flag change.
  - Same run handling as S_WB.
- Latency:
  - run accepted at edge N means done is high in cycle N+3 (R-type) or N+1 (illegal).
  - Back-to-back throughput is one R-type per 3 cycles.
- alu_sel/alu_mode hold the latched values in every non-idle state; they are 0 in S_IDLE.
- run is ignored in S_LOAD_A and S_EXEC; the instruction input may change freely there.
- rx==ry is legal: S holds the rx value and in_b reads the same register.
- Write-back to rx in the same instruction that read it is correct, because S and C already hold the operands/result.
- en_s, en_c and en_i are mutually exclusive in every cycle.

Optional Feature:
- Macro: BITTY_SEQ_PERF_EN.
- When defined:
  - Adds output retired_count [COUNT_W-1:0], reset to 0.
  - Increments on every done pulse, illegal ones included.
  - Wraps from all-ones to 0 without saturating.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package bitty_seq_pkg holds:
  - State enum: S_IDLE, S_LOAD_A, S_EXEC, S_WB, S_DONE_NOP.
  - Field bit positions and the FMT_RTYPE=2'b00 code.
  - MUX_SEL_C constant.
- Sub-module bitty_instr_decode: combinational; takes the latched instruction and outputs rx, ry, alu_sel, alu_mode, is_rtype.
- The top level holds the FSM, latch, flags and optional counter.

Test Plan:
- Reset and illegal accepted:
  - Assert reset_n=0 mid-S_EXEC, then release -> all outputs 0, state S_IDLE, flags 0, and no en_i pulse observed.
  - Then run=1 with 0x0003 -> done+illegal in the following cycle, and no en_s/en_c/en_i asserted.
- R-type ADD:
  - Stimulus: instruction 0x2640 (rx=1, ry=1, sel=1001, mode=0), run pulse; ALU model r1=0x8000 drives carry=1.
  - Response: cycle+1 mux_sel=1, en_s; cycle+2 mux_sel=1, en_c, alu_sel=9; cycle+3 mux_sel=8, en_i=8'b0000_0010, done; then flag_carry=1, flag_eq=1.
- Back-to-back:
  - Stimulus: run held high for three instructions (R, illegal, R).
  - Response: done at cycles 3, 4, 7 after the first accept; illegal only at cycle 4; busy never drops between them.
- Mode 1 XOR:
  - Stimulus: 0xE1A0 (rx=7, ry=0, sel=0110, mode=1).
  - Response: alu_mode=1, alu_sel=6 in S_EXEC; en_i=8'b1000_0000 in S_WB.
- Run ignored:
  - Stimulus: toggle run and instruction during S_LOAD_A/S_EXEC.
  - Response: the latched fields are unchanged and only one done is issued.
- Counter wrap (BITTY_SEQ_PERF_EN defined, COUNT_W=4):
  - Stimulus: 17 instructions.
  - Response: retired_count=1 after wrapping through 15 to 0.
